jump_sequencer: RTL and testbench

JUMP_SEQUENCER -- requirements
Module: jump_sequencer

---
 rtl/jump_sequencer.sv | 165 ++++++++++++++++
 tb/tb_jump_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jump_sequencer.sv
// Jump game sequencer: idle/armed/air/over FSM driving jump commands and the score.
// Define JUMP_QUEUE_EN to buffer one press made while airborne and replay it after landing.
module jump_sequencer #(
    parameter int LAND_TIMEOUT_MS = 100,
    parameter int SCORE_WIDTH     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   one_ms_tick,
    input  logic                   landed,
    input  logic                   game_over,
    output logic                   module_en,
    output logic                   jump_left,
    output logic                   jump_right,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   in_air
);

    localparam int CNT_W = (LAND_TIMEOUT_MS < 1) ? 1 : $clog2(LAND_TIMEOUT_MS + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX   = CNT_W'(LAND_TIMEOUT_MS);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_AIR   = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    logic [1:0]             state, state_d;
    logic                   btn_left_q, btn_right_q;
    logic [CNT_W-1:0]       cnt, cnt_d, cnt_inc;
    logic                   released, released_d;
    logic [SCORE_WIDTH-1:0] score_d;
    logic                   jl_d, jr_d;
    logic                   press_l, press_r, any_press, both_low;
    logic                   launch, launch_right;
`ifdef JUMP_QUEUE_EN
    logic                   q_valid, q_valid_d;
    logic                   q_right, q_right_d;
`endif

    assign press_l   = btn_left & ~btn_left_q;
    assign press_r   = btn_right & ~btn_right_q;
    assign any_press = press_l | press_r;
    assign both_low  = ~btn_left_q & ~btn_right_q;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_d      = state;
        score_d      = score;
        cnt_d        = cnt;
        released_d   = released;
        jl_d         = 1'b0;
        jr_d         = 1'b0;
        launch       = 1'b0;
        launch_right = 1'b0;
`ifdef JUMP_QUEUE_EN
        q_valid_d    = q_valid;
        q_right_d    = q_right;
`endif
        case (state)
            S_IDLE: begin
                if (any_press) begin
                    score_d = '0;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (game_over) begin
                    state_d    = S_OVER;
                    released_d = 1'b0;
                end else begin
                    launch       = any_press;
                    launch_right = press_r & ~press_l;
`ifdef JUMP_QUEUE_EN
                    // A press buffered during the previous flight wins over a fresh one.
                    if (q_valid) begin
                        launch       = 1'b1;
                        launch_right = q_right;
                        q_valid_d    = 1'b0;
                    end
`endif
                    if (launch) begin
                        jl_d    = ~launch_right;
                        jr_d    = launch_right;
                        cnt_d   = '0;
                        state_d = S_AIR;
                    end
                end
            end
            S_AIR: begin
                if (game_over) begin
                    state_d    = S_OVER;
                    released_d = 1'b0;
                end else if (landed) begin
                    score_d = (score == SCORE_MAX) ? score : score + SCORE_WIDTH'(1);
                    state_d = S_ARMED;
                end else if (one_ms_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_MAX) begin
                        state_d    = S_OVER;
                        released_d = 1'b0;
                    end
                end
`ifdef JUMP_QUEUE_EN
                if (state_d != S_OVER && any_press) begin
                    q_valid_d = 1'b1;
                    q_right_d = press_r & ~press_l;
                end
`endif
            end
            default: begin
                // Buttons held when the game ended must be let go before a restart press counts.
                if (both_low)
                    released_d = 1'b1;
                if (any_press && (released || both_low))
                    state_d = S_IDLE;
            end
        endcase
`ifdef JUMP_QUEUE_EN
        if (state_d == S_OVER)
            q_valid_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
            cnt         <= '0;
            released    <= 1'b0;
            score       <= '0;
            module_en   <= 1'b0;
            jump_left   <= 1'b0;
            jump_right  <= 1'b0;
            in_air      <= 1'b0;
        end else begin
            state       <= state_d;
            btn_left_q  <= btn_left;
            btn_right_q <= btn_right;
            cnt         <= cnt_d;
            released    <= released_d;
            score       <= score_d;
            module_en   <= (state_d != S_IDLE);
            jump_left   <= jl_d;
            jump_right  <= jr_d;
            in_air      <= (state_d == S_AIR);
        end
    end

`ifdef JUMP_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_right <= 1'b0;
        end else begin
            q_valid <= q_valid_d;
            q_right <= q_right_d;
        end
    end
`endif

endmodule

// File: tb/tb_jump_sequencer.sv
// Self-checking bench for jump_sequencer: vector table plus hand-written timeout, queue and reset sequences.
module tb_jump_sequencer;

    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_left = 1'b0, btn_right = 1'b0;
    logic          one_ms_tick = 1'b0, landed = 1'b0, game_over = 1'b0;
    logic          module_en, jump_left, jump_right, in_air;
    logic [SW-1:0] score;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic bl, br, tk, ld, go;
        logic en, jl, jr, air;
        int unsigned sc;
    } vec_t;

    typedef struct {
        logic en, jl, jr, air;
        int unsigned sc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[31];

    jump_sequencer #(.LAND_TIMEOUT_MS(100), .SCORE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .one_ms_tick(one_ms_tick), .landed(landed), .game_over(game_over),
        .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
        .score(score), .in_air(in_air)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic bl, logic br, logic tk, logic ld, logic go,
                                logic en, logic jl, logic jr, logic air, int unsigned sc);
        vec_t v;
        v.bl = bl; v.br = br; v.tk = tk; v.ld = ld; v.go = go;
        v.en = en; v.jl = jl; v.jr = jr; v.air = air; v.sc = sc;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        btn_left = v.bl; btn_right = v.br; one_ms_tick = v.tk;
        landed = v.ld; game_over = v.go;
        e.en = v.en; e.jl = v.jl; e.jr = v.jr; e.air = v.air; e.sc = v.sc; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        if (module_en !== e.en || jump_left !== e.jl || jump_right !== e.jr ||
            in_air !== e.air || score !== SW'(e.sc)) begin
            mismatched++;
            $display("[TB] FAIL %s: got en=%b jl=%b jr=%b air=%b score=%0d, expected en=%b jl=%b jr=%b air=%b score=%0d",
                     e.name, module_en, jump_left, jump_right, in_air, score,
                     e.en, e.jl, e.jr, e.air, e.sc);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        applyStimulus(v, name);
        checkOutput();
    endtask

    task automatic checkReset(input string name);
        compared++;
        if (module_en !== 1'b0 || jump_left !== 1'b0 || jump_right !== 1'b0 ||
            in_air !== 1'b0 || score !== '0) begin
            mismatched++;
            $display("[TB] FAIL %s: got en=%b jl=%b jr=%b air=%b score=%0d, expected all zero",
                     name, module_en, jump_left, jump_right, in_air, score);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit qen;
`ifdef JUMP_QUEUE_EN
        qen = 1'b1;
`else
        qen = 1'b0;
`endif
        //               bl br tk ld go   en jl jr air sc
        vecs[0]  = mk(0, 1, 0, 0, 0,   1, 0, 0, 0, 0);  // idle press -> armed
        vecs[1]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0,   1, 1, 0, 1, 0);  // left jump
        vecs[3]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0);  // pulse is one cycle
        vecs[4]  = mk(0, 0, 0, 1, 0,   1, 0, 0, 0, 1);  // landed
        vecs[5]  = mk(0, 0, 0, 1, 0,   1, 0, 0, 0, 1);  // landed ignored in armed
        vecs[6]  = mk(1, 1, 0, 0, 0,   1, 1, 0, 1, 1);  // both -> left only
        vecs[7]  = mk(0, 0, 1, 0, 0,   1, 0, 0, 1, 1);
        vecs[8]  = mk(0, 0, 1, 1, 0,   1, 0, 0, 0, 2);  // landed beats tick
        vecs[9]  = mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 2);  // right jump
        vecs[10] = mk(0, 0, 0, 1, 1,   1, 0, 0, 0, 2);  // game_over beats landed
        vecs[11] = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 2);
        vecs[12] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 2);  // over -> idle, score held
        vecs[13] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
        vecs[14] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 2);  // landed ignored in idle
        vecs[15] = mk(0, 1, 0, 0, 0,   1, 0, 0, 0, 0);  // idle press clears score
        vecs[16] = mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0);  // game_over in armed
        vecs[17] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[21] = mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 0);  // game_over beats press
        vecs[22] = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[23] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vecs[25] = mk(0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[26] = mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 0);  // over with right held
        vecs[27] = mk(1, 1, 0, 0, 0,   1, 0, 0, 0, 0);  // press ignored, right held
        vecs[28] = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[29] = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[30] = mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // release seen -> idle

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkReset("reset_state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 31; i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // Timeout: score 1 then airborne with ticks every other cycle.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to_idle");
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "to_arm");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "to_arm_hold");
        step(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0), "to_jump1");
        step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1), "to_land1");
        step(mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 1), "to_jump2");
        for (int i = 1; i <= 100; i++) begin
            step(mk(0, 0, 1, 0, 0, 1, 0, 0, (i < 100), 1), $sformatf("to_tick%0d", i));
            if (i < 100)
                step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1), $sformatf("to_gap%0d", i));
        end
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "to_over_exit");

        // Press made while airborne, replayed two edges after landed when queued.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "q_idle");
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "q_arm");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "q_arm_hold");
        step(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0), "q_jump");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0), "q_air");
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 0), "q_press_air");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0), "q_air2");
        step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1), "q_land");
        step(mk(0, 0, 0, 0, 0, 1, 0, qen, qen, 1), "q_replay");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, qen, 1), "q_after");

        // Reset asserted mid-flight.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkReset("reset_clean");
        @(negedge clk);
        rst = 1'b0;
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "r_arm");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "r_arm_hold");
        step(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0), "r_jump1");
        step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1), "r_land1");
        step(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1), "r_jump2");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1), "r_air");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkReset("reset_mid_air");
        @(negedge clk);
        rst = 1'b0;
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "r_landed_after_reset");
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "r_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
